// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage: FIFO entry layout and FSM states.
package if_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [31:0]             instr;
    } fetch_entry_t;

    typedef enum logic {
        RST,
        RUN
    } if_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decode-side handshake.
interface if_fetch_unit_if #(
    parameter int XLEN = if_pkg::XLEN_DEFAULT
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_instr;

    modport master (
        output imem_req, imem_addr, id_valid, id_pc, id_instr,
        input  imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_pc, id_instr,
        output imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries with synchronous flush.
// Latency: a push is visible at the head the cycle after the pushing edge.
// Backpressure: none internally; the producer must never push when full.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_if,
    input  logic          reset,
    input  logic          push,
    input  T              push_dat,
    input  logic          pop,
    input  logic          flush,
    output T              head_dat,
    output logic          head_vld,
    output logic [CW-1:0] occupancy
);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_if) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            // flush wins over a same-edge push; a same-edge pop is already done
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_if) begin
        if (!reset) assert (!(push && !flush && count_q == CW'(DEPTH)));
    end

    assign head_dat  = mem[rd_ptr];
    assign head_vld  = (count_q != '0);
    assign occupancy = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues sequential word reads, buffers {pc, instr} for decode.
// Latency: 2 cycles from imem_req to id_valid; 1 instr/cycle sustained.
// Backpressure: issue throttled so buffered + in-flight words never exceed BUF_DEPTH.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk_if,
    input  logic            reset,
    if_fetch_unit_if.master bus
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    if_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic            inflight_q;
    logic            kill_q;

    logic            issue, push, pop, flush;
    logic [CW:0]     pending;
    logic [CW-1:0]   occupancy;
    logic            head_vld;
    fetch_entry_t    push_dat, head_dat;

    assign pop     = head_vld & bus.id_ready;
    assign pending = {1'b0, occupancy} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            RST: state_d = RUN;
            RUN: begin
                flush = bus.redirect_valid;
                issue = !bus.redirect_valid && (pending < (CW + 1)'(BUF_DEPTH));
                push  = inflight_q && !kill_q && !bus.redirect_valid;
            end
            default: state_d = RST;
        endcase
    end

    always_ff @(posedge clk_if) begin
        if (reset) begin
            state_q       <= RST;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            kill_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flush)      pc_q <= bus.redirect_pc & ~XLEN'(3);
            else if (issue) pc_q <= pc_q + XLEN'(4);
            inflight_q <= issue;
            if (issue) inflight_pc_q <= pc_q;
            // a response still owed to the old path must not land after the flush
            kill_q <= flush & inflight_q;
        end
    end

    assign push_dat.pc    = inflight_pc_q;
    assign push_dat.instr = bus.imem_rdata;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk_if    (clk_if),
        .reset     (reset),
        .push      (push),
        .push_dat  (push_dat),
        .pop       (pop),
        .flush     (flush),
        .head_dat  (head_dat),
        .head_vld  (head_vld),
        .occupancy (occupancy)
    );

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_q;
    assign bus.id_valid  = head_vld;
    assign bus.id_pc     = head_dat.pc;
    assign bus.id_instr  = head_dat.instr;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory returns addr>>2, handshakes logged at negedge.
module tb_if_fetch_unit;
    import if_pkg::*;

    logic clk_if = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_if = ~clk_if;

    if_fetch_unit_if #(.XLEN(32)) bus ();

    if_fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (32'h0),
        .BUF_DEPTH (2)
    ) dut (
        .clk_if (clk_if),
        .reset  (reset),
        .bus    (bus)
    );

    // synchronous-read instruction memory
    always @(posedge clk_if) begin
        if (bus.imem_req) bus.imem_rdata <= {2'b00, bus.imem_addr[31:2]};
    end

    logic [31:0] got_pc[$];
    logic [31:0] got_ins[$];
    always @(negedge clk_if) begin
        if (!reset && bus.id_valid && bus.id_ready) begin
            got_pc.push_back(bus.id_pc);
            got_ins.push_back(bus.id_instr);
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one cycle, drive inputs early in the cycle, leave time for outputs to settle
    task automatic cyc(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk_if);
        #2;
        reset              = rst;
        bus.id_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
    endtask

    // ends inside the first cycle with reset low (state still RST)
    task automatic do_reset(input logic rdy);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        got_pc.delete();
        got_ins.delete();
        cyc(1'b0, rdy, 1'b0, 32'h0);
    endtask

    int reqs;

    initial begin
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_rdata     = 32'h0;

        // reset values and streaming
        do_reset(1'b1);
        check_eq("rst_req",   bus.imem_req,  0);
        check_eq("rst_addr",  bus.imem_addr, 0);
        check_eq("rst_valid", bus.id_valid,  0);
        check_eq("rst_pc",    bus.id_pc,     0);
        check_eq("rst_instr", bus.id_instr,  0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("c1_req",   bus.imem_req,  1);
        check_eq("c1_addr",  bus.imem_addr, 0);
        check_eq("c1_valid", bus.id_valid,  0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("c2_addr",  bus.imem_addr, 4);
        check_eq("c2_valid", bus.id_valid,  0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            check_eq("stream_valid", bus.id_valid, 1);
            check_eq("stream_pc",    bus.id_pc,    64'(4 * i));
            check_eq("stream_instr", bus.id_instr, 64'(i));
        end

        // decode stalled: only BUF_DEPTH requests go out
        do_reset(1'b0);
        reqs = 0;
        for (int i = 1; i <= 7; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            reqs += int'(bus.imem_req);
            if (i == 3) check_eq("stall_pc_c3", bus.id_pc, 0);
        end
        check_eq("stall_reqs",  reqs,         2);
        check_eq("stall_valid", bus.id_valid, 1);
        check_eq("stall_pc_c7", bus.id_pc,    0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("release_count", got_pc.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check_eq("release_pc",    got_pc[i],  64'(4 * i));
            check_eq("release_instr", got_ins[i], 64'(i));
        end

        // redirect with a request in flight
        do_reset(1'b1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 32'h103);
        check_eq("redir_noissue", bus.imem_req, 0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("redir_req",    bus.imem_req,  1);
        check_eq("redir_addr",   bus.imem_addr, 32'h100);
        check_eq("redir_valid1", bus.id_valid,  0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("redir_addr2",  bus.imem_addr, 32'h104);
        check_eq("redir_valid2", bus.id_valid,  0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("redir_valid3", bus.id_valid, 1);
        check_eq("redir_pc",     bus.id_pc,    32'h100);
        check_eq("redir_instr",  bus.id_instr, 32'h40);

        // redirect coinciding with a handshake on pc 8
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 32'h200);
        check_eq("hs_valid", bus.id_valid, 1);
        check_eq("hs_pc",    bus.id_pc,    8);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("hs_flushed",  bus.id_valid,  0);
        check_eq("hs_new_addr", bus.imem_addr, 32'h200);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("hs_target_pc", bus.id_pc, 32'h200);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("hs_count", got_pc.size(), 4);
        check_eq("hs_pc8",   got_pc[2],     8);
        check_eq("hs_next",  got_pc[3],     32'h200);

        // PC wrap at the top of the address space
        do_reset(1'b1);
        cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        check_eq("wrap_noissue", bus.imem_req, 0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("wrap_addr_zero", bus.imem_addr, 0);
        check_eq("wrap_req",       bus.imem_req,  1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("wrap_pc_top",    bus.id_pc,    32'hFFFF_FFFC);
        check_eq("wrap_instr_top", bus.id_instr, 32'h3FFF_FFFF);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("wrap_pc_zero", bus.id_pc, 0);

        // reset mid-stream with data buffered and a response in flight
        do_reset(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("mid_rst_valid", bus.id_valid,  0);
        check_eq("mid_rst_req",   bus.imem_req,  0);
        check_eq("mid_rst_addr",  bus.imem_addr, 0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("restart_req",  bus.imem_req,  1);
        check_eq("restart_addr", bus.imem_addr, 0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("restart_valid", bus.id_valid, 1);
        check_eq("restart_pc",    bus.id_pc,    0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
